tdm_mux_nx1: RTL and testbench

//  Parametrised, registered N:1 multiplexer of W-bit channels with two modes: manual
//  (external select) and auto-scan (internal round-robin pointer with per-channel dwell).

---
 rtl/tdm_mux_nx1.sv | 87 ++++++++
 tb/tb_tdm_mux_nx1.sv | 133 +++++++++++++
 2 files changed

// File: rtl/tdm_mux_nx1.sv
// tdm_mux_nx1: registered N:1 channel mux with manual select and round-robin auto-scan
module tdm_mux_nx1 #(
    parameter int N    = 10,
    parameter int W    = 1,
    parameter int SELW = 4,
    parameter int HOLD = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  i,
    input  logic [SELW-1:0] s,
    input  logic            mode,
    input  logic            en,
    output logic [W-1:0]    y,
    output logic [SELW-1:0] ch,
    output logic            valid,
    output logic            err,
    output logic            sof
);
    localparam int DW = HOLD > 1 ? $clog2(HOLD) : 1;
    typedef enum logic [1:0] {MAN, SCAN, PAUSE} state_t;
    state_t state, state_n;
    logic [SELW-1:0] ptr, ptr_n, p, ch_n;
    logic [DW-1:0] dwell, dwell_n, d;
    logic [W-1:0] y_n, man_d, scan_d;
    logic valid_n, err_n, sof_n, s_ok;
    // Scan position is only meaningful in SCAN/PAUSE; entering from MAN restarts at channel 0.
    assign p = state == MAN ? '0 : ptr;
    assign d = state == MAN ? '0 : dwell;
    assign s_ok = {1'b0, s} < (SELW+1)'(N);
    always_comb begin
        man_d = '0;
        scan_d = '0;
        for (int k = 0; k < N; k++) begin
            if (s == SELW'(k)) man_d = i[k*W +: W];
            if (p == SELW'(k)) scan_d = i[k*W +: W];
        end
    end
    always_comb begin
        state_n = state;
        ptr_n = ptr;
        dwell_n = dwell;
        y_n = y;
        ch_n = ch;
        valid_n = 1'b0;
        err_n = 1'b0;
        sof_n = 1'b0;
        if (en && mode) begin
            state_n = SCAN;
            y_n = scan_d;
            ch_n = p;
            valid_n = 1'b1;
            sof_n = p == '0 && d == '0;
            dwell_n = d == DW'(HOLD-1) ? '0 : d + DW'(1);
            ptr_n = d != DW'(HOLD-1) ? p : p == SELW'(N-1) ? '0 : p + SELW'(1);
        end else if (en) begin
            state_n = MAN;
            y_n = s_ok ? man_d : '0;
            ch_n = s;
            valid_n = s_ok;
            err_n = !s_ok;
        end else if (state != MAN) begin
            state_n = PAUSE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MAN;
            ptr <= '0;
            dwell <= '0;
            y <= '0;
            ch <= '0;
            valid <= 1'b0;
            err <= 1'b0;
            sof <= 1'b0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            dwell <= dwell_n;
            y <= y_n;
            ch <= ch_n;
            valid <= valid_n;
            err <= err_n;
            sof <= sof_n;
        end
    end
endmodule

// File: tb/tb_tdm_mux_nx1.sv
// tb_tdm_mux_nx1: directed scoreboard bench over three tdm_mux_nx1 configurations
module tb_tdm_mux_nx1;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic [9:0] i0, i1, pat;
    logic [39:0] i2;
    logic [3:0] s0, s1, s2, ch0, ch1, ch2;
    logic m0, m1, m2, e0, e1, e2;
    logic y0, y1, v0, v1, v2, er0, er1, er2, sf0, sf1, sf2;
    logic [7:0] y2;
    tdm_mux_nx1 #(.N(10), .W(1), .SELW(4), .HOLD(1)) u0 (.clk(clk), .rst(rst), .i(i0), .s(s0), .mode(m0), .en(e0),
        .y(y0), .ch(ch0), .valid(v0), .err(er0), .sof(sf0));
    tdm_mux_nx1 #(.N(10), .W(1), .SELW(4), .HOLD(3)) u1 (.clk(clk), .rst(rst), .i(i1), .s(s1), .mode(m1), .en(e1),
        .y(y1), .ch(ch1), .valid(v1), .err(er1), .sof(sf1));
    tdm_mux_nx1 #(.N(5), .W(8), .SELW(4), .HOLD(1)) u2 (.clk(clk), .rst(rst), .i(i2), .s(s2), .mode(m2), .en(e2),
        .y(y2), .ch(ch2), .valid(v2), .err(er2), .sof(sf2));
    typedef struct {
        int due;
        int id;
        logic [7:0] y;
        logic [3:0] ch;
        logic v, e, f;
        string tag;
    } exp_t;
    exp_t q[$];
    exp_t x;
    int cyc = 0, checks = 0, errors = 0;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [14:0] obs(int id);
        return id == 0 ? {7'b0, y0, ch0, v0, er0, sf0} : id == 1 ? {7'b0, y1, ch1, v1, er1, sf1} : {y2, ch2, v2, er2, sf2};
    endfunction
    task automatic chk(string tag, logic [14:0] got, logic [14:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got y=%h ch=%0d valid=%b err=%b sof=%b, expected y=%h ch=%0d valid=%b err=%b sof=%b",
                tag, got[14:7], got[6:3], got[2], got[1], got[0], want[14:7], want[6:3], want[2], want[1], want[0]);
        end
    endtask
    task automatic push(int id, string tag, logic [7:0] y, logic [3:0] ch, logic v, logic e, logic f);
        q.push_back('{cyc + 1, id, y, ch, v, e, f, tag});
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk)
        while (q.size() != 0 && q[0].due <= cyc) begin
            x = q.pop_front();
            chk(x.tag, x.due == cyc ? obs(x.id) : 15'h7fff, {x.y, x.ch, x.v, x.e, x.f});
        end
    initial begin
        pat = 10'b1010101011;
        i0 = pat;
        i1 = pat;
        i2 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        {s0, s1, s2, m0, m1, m2, e0, e1, e2} = '0;
        #1;
        chk("reset_u0", obs(0), 15'h0);
        chk("reset_u1", obs(1), 15'h0);
        chk("reset_u2", obs(2), 15'h0);
        tick;
        rst = 1'b0;
        e0 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            s0 = 4'(k);
            push(0, "t2_manual", k < 10 ? 8'(pat[k]) : 8'h0, 4'(k), k < 10, k >= 10, 1'b0);
            tick;
        end
        m0 = 1'b1;
        for (int k = 0; k < 25; k++) begin
            push(0, "t3_scan", 8'(pat[k % 10]), 4'(k % 10), 1'b1, 1'b0, k % 10 == 0);
            tick;
        end
        e0 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push(0, "t5_pause", 8'(pat[4]), 4'd4, 1'b0, 1'b0, 1'b0);
            tick;
        end
        e0 = 1'b1;
        push(0, "t5_resume", 8'(pat[5]), 4'd5, 1'b1, 1'b0, 1'b0);
        tick;
        push(0, "t5_next", 8'(pat[6]), 4'd6, 1'b1, 1'b0, 1'b0);
        tick;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t1_async_rst", obs(0), 15'h0);
        tick;
        rst = 1'b0;
        push(0, "t1_after_rst", 8'(pat[0]), 4'd0, 1'b1, 1'b0, 1'b1);
        tick;
        push(0, "t1_after_rst2", 8'(pat[1]), 4'd1, 1'b1, 1'b0, 1'b0);
        tick;
        e0 = 1'b0;
        m1 = 1'b1;
        e1 = 1'b1;
        for (int k = 0; k < 65; k++) begin
            push(1, "t4_hold3", 8'(pat[(k / 3) % 10]), 4'((k / 3) % 10), 1'b1, 1'b0, k % 30 == 0);
            tick;
        end
        e1 = 1'b0;
        m2 = 1'b1;
        e2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push(2, "t6_scan", 8'((k + 1) * 17), 4'(k), 1'b1, 1'b0, k == 0);
            tick;
        end
        m2 = 1'b0;
        s2 = 4'd2;
        push(2, "t6_manual", 8'h33, 4'd2, 1'b1, 1'b0, 1'b0);
        tick;
        s2 = 4'd5;
        push(2, "t6_oor5", 8'h0, 4'd5, 1'b0, 1'b1, 1'b0);
        tick;
        s2 = 4'd4;
        push(2, "t6_last_ch", 8'h55, 4'd4, 1'b1, 1'b0, 1'b0);
        tick;
        m2 = 1'b1;
        push(2, "t6_rescan", 8'h11, 4'd0, 1'b1, 1'b0, 1'b1);
        tick;
        push(2, "t6_rescan1", 8'h22, 4'd1, 1'b1, 1'b0, 1'b0);
        tick;
        e2 = 1'b0;
        push(2, "t6_freeze", 8'h22, 4'd1, 1'b0, 1'b0, 1'b0);
        tick;
        repeat (2) tick;
        chk("drain", 15'(q.size()), 15'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
